data_mem_resp: RTL and testbench
================================

Name: data_mem_resp

Overview:
- Data-memory responder at the far end of the control unit's memory request interface (MemEnab, MemWrite).
- Accepts one LW/SW access at a time from the EX/MEM stage and services it after a programmable number of wait states.
- Asserts Stall so the pipeline holds the requesting instruction until the access completes.
- Returns read data registered, with a one-cycle Ready pulse at completion.

Parameters:
DSIZE, 16, data word width in bits
ASIZE, 8, word address width; the array holds 2^ASIZE words
WAIT, 2, wait states per access (0..15); the access completes WAIT+1 cycles after the request is first seen

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
MemEnab  input  1  access request from control, active high
MemWrite  input  1  access direction, per control encoding: 0 = write (SW), 1 = read (LW)
Addr  input  ASIZE  word address (ALU result)
WData  input  DSIZE  store data (Rt value)
RData  output  DSIZE  load data, registered
Ready  output  1  one-cycle completion pulse
Stall  output  1  pipeline hold request (freeze PC and IF/ID/EX/MEM registers)

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, cnt=0, RData=0, Ready=0, Stall=0.
  - Latched address, data and direction registers cleared.
  - Memory array is not reset; contents are undefined until written (bench preloads the array).
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Stall = MemEnab (combinational). Ready=0.
  - On the edge with MemEnab=1: latch Addr, WData and MemWrite.
  - If WAIT==0, perform the access on this edge and go to DONE. Otherwise set cnt=WAIT-1 and go to BUSY.
  - MemEnab=0: stay in IDLE.
- BUSY:
  - Stall=1, Ready=0.
  - cnt!=0: cnt decrements.
  - cnt==0: perform the access on this edge and go to DONE.
  - Inputs are ignored in BUSY; only the latched copies are used. A dropped MemEnab does not abort the access.
- Access:
  - Write (latched MemWrite=0): mem[addr] <= wdata. RData is unchanged.
  - Read (latched MemWrite=1): RData <= mem[addr].
- DONE:
  - Ready=1, Stall=0 for exactly one cycle; always returns to IDLE.
  - MemEnab is ignored in DONE because it still belongs to the completing instruction, which advances on the DONE edge.
  - A following request is first seen in IDLE on the next cycle.
- Timing from request cycle t0 (IDLE, MemEnab=1):
  - Stall is high for cycles t0..t0+WAIT.
  - Ready and valid RData appear in cycle t0+WAIT+1.
  - Back-to-back accesses therefore have a period of WAIT+2 cycles.
- RData holds its last read value through writes and idle periods.
- Stall is never asserted in the same cycle as Ready.
- A read immediately after a write to the same address returns the new value, because the write completes before the read is accepted.
- Reset mid-operation (BUSY): the access is abandoned, no array write occurs, and all outputs go to reset values immediately.
- Reset released while MemEnab=1: the request is accepted on the first rising edge after release.
- Address wraps naturally within ASIZE bits; there is no out-of-range case.

Test Plan:
1. Reset, WAIT=2:
   - Stimulus: rst=0 at t=0 then release; MemEnab=0.
   - Required: RData=0, Ready=0, Stall=0.
2. Write then read:
   - Stimulus: SW Addr=8'h10, WData=16'hBEEF, MemWrite=0.
   - Required: Stall high 3 cycles, Ready pulses in cycle 3.
   - Stimulus: then LW Addr=8'h10, MemWrite=1.
   - Required: RData=16'hBEEF when Ready=1, Stall high exactly 3 cycles.
3. Back-to-back and hold:
   - Stimulus: LW 8'h01 (preload 16'h1234) immediately followed by LW 8'h02 (preload 16'hABCD), MemEnab held high through DONE.
   - Required: Ready at cycles 3 and 7, RData=16'h1234 then 16'hABCD. The DONE-cycle MemEnab does not start a third access.
4. Abort:
   - Stimulus: SW Addr=8'h20, WData=16'h5555; assert rst=0 in the second BUSY cycle; release, then LW 8'h20 (preload 16'h0000).
   - Required: RData=16'h0000, and Stall/Ready drop asynchronously at reset.
5. WAIT=0 build:
   - Stimulus: LW 8'hFF (preload 16'h8001).
   - Required: Stall high 1 cycle, Ready and RData=16'h8001 in the next cycle.
6. Input change in BUSY:
   - Stimulus: SW Addr=8'h30, WData=16'h00AA; change Addr to 8'h31, WData to 16'hFFFF and drop MemEnab during BUSY.
   - Required: mem[8'h30]=16'h00AA, mem[8'h31] unchanged.

Source files
------------

// File: rtl/data_mem_resp.sv
// rtl/data_mem_resp.sv - data-memory responder with programmable wait states
module data_mem_resp #(
  parameter int DSIZE = 16,
  parameter int ASIZE = 8,
  parameter int WAIT  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MemEnab,
  input  logic             MemWrite,
  input  logic [ASIZE-1:0] Addr,
  input  logic [DSIZE-1:0] WData,
  output logic [DSIZE-1:0] RData,
  output logic             Ready,
  output logic             Stall
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] CNT_INIT = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);
  localparam bit         ZERO_WAIT = (WAIT == 0);

  state_t             state;
  logic [3:0]         cnt;
  logic [ASIZE-1:0]   addr_q;
  logic [DSIZE-1:0]   wdata_q;
  logic               rd_q;

  logic [DSIZE-1:0]   mem [2**ASIZE];

  logic               do_access;
  logic [ASIZE-1:0]   acc_addr;
  logic [DSIZE-1:0]   acc_wdata;
  logic               acc_rd;

  // A zero-wait access fires on the accepting edge straight from the inputs;
  // otherwise only the copies latched at acceptance are used.
  always_comb begin
    do_access = 1'b0;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_rd    = rd_q;
    if (state == IDLE) begin
      acc_addr  = Addr;
      acc_wdata = WData;
      acc_rd    = MemWrite;
      do_access = MemEnab && ZERO_WAIT;
    end else if (state == BUSY) begin
      do_access = (cnt == 4'd0);
    end
    do_access = do_access && rst;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      RData   <= '0;
    end else begin
      if (do_access && acc_rd)
        RData <= mem[acc_addr];
      case (state)
        IDLE: begin
          if (MemEnab) begin
            addr_q  <= Addr;
            wdata_q <= WData;
            rd_q    <= MemWrite;
            if (ZERO_WAIT) begin
              state <= DONE;
            end else begin
              cnt   <= CNT_INIT;
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (cnt == 4'd0)
            state <= DONE;
          else
            cnt <= cnt - 4'd1;
        end
        // MemEnab here still belongs to the completing instruction.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_access && !acc_rd)
      mem[acc_addr] <= acc_wdata;
  end

  assign Ready = (state == DONE);
  assign Stall = rst && (((state == IDLE) && MemEnab) || (state == BUSY));

endmodule

// File: tb/tb_data_mem_resp.sv
// tb/tb_data_mem_resp.sv - directed self-checking bench for data_mem_resp
module tb_data_mem_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, en_w0;
  logic        MemWrite;
  logic [7:0]  Addr;
  logic [15:0] WData;
  logic [15:0] RData, rdata_w0;
  logic        Ready, Stall, ready_w0, stall_w0;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          rc1, rc2;
  logic [15:0] last_rd [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_resp #(.DSIZE(16), .ASIZE(8), .WAIT(2)) dut (
    .clk(clk), .rst(rst), .MemEnab(en), .MemWrite(MemWrite), .Addr(Addr),
    .WData(WData), .RData(RData), .Ready(Ready), .Stall(Stall)
  );

  data_mem_resp #(.DSIZE(16), .ASIZE(8), .WAIT(0)) dut_w0 (
    .clk(clk), .rst(rst), .MemEnab(en_w0), .MemWrite(MemWrite), .Addr(Addr),
    .WData(WData), .RData(rdata_w0), .Ready(ready_w0), .Stall(stall_w0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    en    = 1'b0;
    en_w0 = 1'b0;
    @(posedge clk); #1;
  endtask

  // One access with MemEnab held through DONE; for reads d is the expected data.
  // perturb changes Addr/WData and drops MemEnab in the first BUSY cycle.
  task automatic access(input logic sel, input logic rd, input logic [7:0] a,
                        input logic [15:0] d, input bit perturb, input string tag,
                        output int rc);
    int   w;
    int   n_stall;
    int   i;
    logic got;
    logic rdy, stl;
    logic [15:0] rdat;
    w       = sel ? 0 : 2;
    n_stall = 0;
    i       = 0;
    got     = 1'b0;
    rc      = -1;
    MemWrite = rd;
    Addr     = a;
    WData    = rd ? 16'h0000 : d;
    if (sel) en_w0 = 1'b1; else en = 1'b1;
    while (!got && i < 40) begin
      if (perturb && i == 1) begin
        Addr  = a + 8'd1;
        WData = 16'hFFFF;
        en    = 1'b0;
      end
      @(negedge clk);
      rdy  = sel ? ready_w0 : Ready;
      stl  = sel ? stall_w0 : Stall;
      rdat = sel ? rdata_w0 : RData;
      if (rdy) begin
        got = 1'b1;
        rc  = cyc;
        chk({tag, "_ready_cycle"}, 32'(i), 32'(w + 1));
        chk({tag, "_stall_cycles"}, 32'(n_stall), 32'(w + 1));
        chk({tag, "_stall_with_ready"}, 32'(stl), 32'd0);
        if (rd) begin
          chk({tag, "_rdata"}, 32'(rdat), 32'(d));
          last_rd[sel] = d;
        end else begin
          chk({tag, "_rdata_hold"}, 32'(rdat), 32'(last_rd[sel]));
        end
      end else if (stl) begin
        n_stall++;
      end
      @(posedge clk); #1;
      i++;
    end
    if (!got) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; en_w0 = 1'b0;
    MemWrite = 1'b0; Addr = 8'h00; WData = 16'h0000;
    last_rd[0] = 16'h0000;
    last_rd[1] = 16'h0000;

    // 1. reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdata", 32'(RData), 32'h0);
    chk("rst_ready", 32'(Ready), 32'h0);
    chk("rst_stall", 32'(Stall), 32'h0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_rdata", 32'(RData), 32'h0);
    chk("post_rst_ready", 32'(Ready), 32'h0);
    chk("post_rst_stall", 32'(Stall), 32'h0);

    // 2. write then read same address
    access(1'b0, 1'b0, 8'h10, 16'hBEEF, 1'b0, "t2_sw", rc1);
    idle();
    access(1'b0, 1'b1, 8'h10, 16'hBEEF, 1'b0, "t2_lw", rc1);
    idle();

    // 3. preload, then back-to-back reads with MemEnab held through DONE
    access(1'b0, 1'b0, 8'h01, 16'h1234, 1'b0, "t3_pre1", rc1);
    idle();
    access(1'b0, 1'b0, 8'h02, 16'hABCD, 1'b0, "t3_pre2", rc1);
    idle();
    access(1'b0, 1'b1, 8'h01, 16'h1234, 1'b0, "t3_lw1", rc1);
    access(1'b0, 1'b1, 8'h02, 16'hABCD, 1'b0, "t3_lw2", rc2);
    chk("t3_period", 32'(rc2 - rc1), 32'd4);
    en = 1'b0;
    @(negedge clk);
    chk("t3_no_third_stall", 32'(Stall), 32'h0);
    chk("t3_no_third_ready", 32'(Ready), 32'h0);
    @(posedge clk); #1;

    // 4. reset during the second BUSY cycle abandons the write
    access(1'b0, 1'b0, 8'h20, 16'h0000, 1'b0, "t4_pre", rc1);
    idle();
    MemWrite = 1'b0; Addr = 8'h20; WData = 16'h5555; en = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t4_busy_stall", 32'(Stall), 32'h1);
    rst = 1'b0;
    #1;
    chk("t4_async_stall", 32'(Stall), 32'h0);
    chk("t4_async_ready", 32'(Ready), 32'h0);
    chk("t4_async_rdata", 32'(RData), 32'h0);
    last_rd[0] = 16'h0000;
    last_rd[1] = 16'h0000;
    en = 1'b0;
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    access(1'b0, 1'b1, 8'h20, 16'h0000, 1'b0, "t4_lw", rc1);
    idle();

    // 6. input changes during BUSY are ignored
    access(1'b0, 1'b0, 8'h31, 16'h1111, 1'b0, "t6_pre", rc1);
    idle();
    access(1'b0, 1'b1, 8'h02, 16'hABCD, 1'b0, "t6_lw_mark", rc1);
    idle();
    access(1'b0, 1'b0, 8'h30, 16'h00AA, 1'b1, "t6_sw", rc1);
    idle();
    access(1'b0, 1'b1, 8'h30, 16'h00AA, 1'b0, "t6_lw30", rc1);
    access(1'b0, 1'b1, 8'h31, 16'h1111, 1'b0, "t6_lw31", rc1);
    idle();

    // 5. zero-wait instance
    access(1'b1, 1'b0, 8'hFF, 16'h8001, 1'b0, "t5_sw", rc1);
    idle();
    access(1'b1, 1'b1, 8'hFF, 16'h8001, 1'b0, "t5_lw", rc1);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
